fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage: generates the `hold_pc`, `hold_if`, `br`, `except` and `pc_branch` controls consumed by the IF stage, plus ID/EX flush strobes. It arbitrates between competing requests:

- exception entry
- branch redirect
- load-use stall
- multi-cycle multiply/divide stall
- post-reset boot hold

It sits between the hazard/branch logic in ID/EX and the IF stage, and latches EPC/cause on exception entry.

## Interface
- `BOOT_CYC`, 2: cycles fetch is held after reset release (≥1).
- `MD_LAT`, 32: multiply/divide busy cycles (≥2).
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load_use`, in, 1: load-use hazard detected in ID this cycle.
- `md_start`, in, 1: mult/div instruction issued from EX this cycle.
- `br_req`, in, 1: taken branch/jump resolved this cycle.
- `br_target`, in, 32: target for `br_req`.
- `exc_req`, in, 1: exception raised this cycle.
- `exc_pc`, in, 32: PC of the faulting instruction.
- `exc_code`, in, 5: cause code.
- `hold_pc`, out, 1: freeze the PC register.
- `hold_if`, out, 1: freeze the IF/ID register.
- `br`, out, 1: select `pc_branch` in the PC mux.
- `except`, out, 1: select the exception vector in the PC mux.
- `pc_branch`, out, 32: redirect target.
- `flush_id`, out, 1: zero the IF/ID instruction.
- `flush_ex`, out, 1: zero the ID/EX instruction.
- `epc`, out, 32: latched exception PC.
- `cause`, out, 5: latched cause.

## Operation
- **States:** BOOT, RUN, MD_WAIT, EXC_SHADOW.
- **Counter:** one down-counter, width $clog2(max(BOOT_CYC, MD_LAT)), shared by BOOT and MD_WAIT.
- **Reset:** `rst`=1 → state BOOT, counter=BOOT_CYC-1, `epc`=0, `cause`=0. All request inputs are ignored while `rst`=1.
- **BOOT:**
  - `hold_pc`=`hold_if`=1; all other outputs 0.
  - Counter decrements; at 0 → RUN.
  - Requests are ignored in BOOT.
- **RUN:** outputs are decoded combinationally from the inputs, priority exc > br > md > load_use.
  - **exc_req:** `except`=1, `flush_id`=`flush_ex`=1, `hold_pc`=`hold_if`=0. Latch `epc`←`exc_pc`, `cause`←`exc_code`. Next state EXC_SHADOW.
  - **br_req** (no exc): `br`=1, `pc_branch`=`br_target`, `flush_id`=1, holds 0. Stays in RUN. A simultaneous `load_use` is dropped, because the stalled instruction is in the branch shadow.
  - **md_start** (no exc/br): `hold_pc`=`hold_if`=1 this cycle; counter←MD_LAT-2; → MD_WAIT.
  - **load_use only:** `hold_pc`=`hold_if`=1, `flush_ex`=1 (bubble) for that cycle only. The requester keeps `load_use` high for as long as the hazard persists.
- **MD_WAIT:**
  - `hold_pc`=`hold_if`=1; counter decrements; at 0 → RUN.
  - `exc_req` aborts the wait: same outputs and latch as in RUN, → EXC_SHADOW.
  - `br_req`, `md_start`, `load_use` are ignored.
- **EXC_SHADOW:**
  - One cycle with all outputs 0 (fetching vector); then RUN.
  - `br_req`, `md_start` and `load_use` are ignored.
  - `exc_req` is honoured: same outputs and latch as in RUN, stays in EXC_SHADOW for one further cycle.
- **Mutual exclusion:** `br` and `except` are never both 1. `pc_branch` is 0 whenever `br`=0.
- **EPC/cause:** `epc`/`cause` change only on accepted exceptions.

## Timing
- All outputs are combinational from state and current inputs; the only registers are state, counter, `epc` and `cause`.
- **Redirect:** zero latency. `br`/`except` are asserted in the request cycle, and the PC register loads the target at the next edge.
- **Boot:** after the `rst` falling edge, hold lasts exactly BOOT_CYC cycles.
- **Mult/div:** hold lasts exactly MD_LAT cycles, counting the `md_start` cycle.
- **Reset mid-operation:** `rst` in any state → BOOT at the next edge; outputs hold=1 from the following cycle.
- **Counter:** never wraps; it is reloaded only on state entry.

## Test plan
- **Boot:** deassert `rst`, BOOT_CYC=2 → `hold_pc`=`hold_if`=1 for exactly 2 cycles, then 0; `epc`=0, `cause`=0.
- **Branch over load-use:** in RUN, `br_req`=1, `br_target`=0x0000_0040, `load_use`=1 → same cycle `br`=1, `pc_branch`=0x40, `flush_id`=1, `hold_pc`=0, `flush_ex`=0.
- **Exception over branch:** `exc_req`=1, `exc_pc`=0x0000_0010, `exc_code`=12, `br_req`=1 in the same cycle:
  - That cycle: `except`=1, `br`=0, `flush_id`=`flush_ex`=1.
  - Next cycle: `epc`=0x10, `cause`=12.
  - `br_req` in the next cycle is ignored.
- **Mult/div, then branch:** `md_start` with MD_LAT=32 → `hold_pc`=1 for exactly 32 cycles. `br_req` during the wait has no effect. The first cycle back in RUN responds to `br_req`.
- **Exception aborts mult/div:** `exc_req` in cycle 5 of MD_WAIT → `except`=1 that cycle, holds drop to 0, one EXC_SHADOW cycle, then RUN.
- **Load-use, then reset:** `load_use` held 3 cycles → `hold_pc`=`hold_if`=`flush_ex`=1 for exactly those 3 cycles. Then `rst` pulse mid-run → BOOT sequence repeats; `epc`/`cause` return to 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing controller.
// Arbitrates exception entry, branch redirect, mult/div stall, load-use
// stall and the post-reset boot hold. It also latches EPC/cause when an
// exception is accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_use            load-use hazard in ID this cycle
//   md_start            mult/div issued from EX this cycle
//   br_req, br_target   taken branch/jump and its target
//   exc_req             exception raised this cycle
//   exc_pc, exc_code    PC of the faulting instruction and its cause code
//   hold_pc, hold_if    freeze the PC register / IF-ID register
//   br, pc_branch       PC mux branch select and redirect target
//   except              PC mux exception-vector select
//   flush_id, flush_ex  zero the IF/ID and ID/EX instructions
//   epc, cause          latched exception PC and cause
// All outputs are combinational from the current state and inputs.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYC = 2,
  parameter int unsigned MD_LAT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        md_start,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic [4:0]  exc_code,
  output logic        hold_pc,
  output logic        hold_if,
  output logic        br,
  output logic        except,
  output logic [31:0] pc_branch,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [31:0] epc,
  output logic [4:0]  cause
);

  localparam int unsigned CNT_MAX = (BOOT_CYC > MD_LAT) ? BOOT_CYC : MD_LAT;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MD_WAIT,
    EXC_SHADOW
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    epc_q;
  logic [4:0]     cause_q;
  logic           take_exc;

  // Requests are masked while reset is asserted so nothing is accepted
  // in the reset cycle, whatever state the controller happens to be in.
  logic exc_v, br_v, md_v, lu_v;
  assign exc_v = exc_req  & ~rst;
  assign br_v  = br_req   & ~rst;
  assign md_v  = md_start & ~rst;
  assign lu_v  = load_use & ~rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_exc  = 1'b0;
    hold_pc   = 1'b0;
    hold_if   = 1'b0;
    br        = 1'b0;
    except    = 1'b0;
    pc_branch = '0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;

    unique case (state_q)
      BOOT: begin
        hold_pc = 1'b1;
        hold_if = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (exc_v) begin
          except   = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          take_exc = 1'b1;
          state_d  = EXC_SHADOW;
        end else if (br_v) begin
          // A coincident load-use is dropped: the stalled instruction
          // sits in the branch shadow and is flushed anyway.
          br        = 1'b1;
          pc_branch = br_target;
          flush_id  = 1'b1;
        end else if (md_v) begin
          hold_pc = 1'b1;
          hold_if = 1'b1;
          // The md_start cycle is the first of MD_LAT held cycles, and
          // MD_WAIT runs the counter down through zero inclusive.
          cnt_d   = CW'(MD_LAT - 2);
          state_d = MD_WAIT;
        end else if (lu_v) begin
          hold_pc  = 1'b1;
          hold_if  = 1'b1;
          flush_ex = 1'b1;
        end
      end

      MD_WAIT: begin
        if (exc_v) begin
          except   = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          take_exc = 1'b1;
          state_d  = EXC_SHADOW;
        end else begin
          hold_pc = 1'b1;
          hold_if = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      EXC_SHADOW: begin
        if (exc_v) begin
          except   = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          take_exc = 1'b1;
          state_d  = EXC_SHADOW;
        end else begin
          state_d = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= CW'(BOOT_CYC - 1);
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_exc) begin
        epc_q   <= exc_pc;
        cause_q <= exc_code;
      end
    end
  end

  assign epc   = epc_q;
  assign cause = cause_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with default parameters (BOOT_CYC=2, MD_LAT=32).
// The driver applies one input vector per cycle and queues the expected
// output word; the monitor pops and compares it at the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use;
  logic        md_start;
  logic        br_req;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [4:0]  exc_code;
  logic        hold_pc;
  logic        hold_if;
  logic        br;
  logic        except;
  logic [31:0] pc_branch;
  logic        flush_id;
  logic        flush_ex;
  logic [31:0] epc;
  logic [4:0]  cause;

  fetch_ctrl #(
    .BOOT_CYC(2),
    .MD_LAT  (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_use (load_use),
    .md_start (md_start),
    .br_req   (br_req),
    .br_target(br_target),
    .exc_req  (exc_req),
    .exc_pc   (exc_pc),
    .exc_code (exc_code),
    .hold_pc  (hold_pc),
    .hold_if  (hold_if),
    .br       (br),
    .except   (except),
    .pc_branch(pc_branch),
    .flush_id (flush_id),
    .flush_ex (flush_ex),
    .epc      (epc),
    .cause    (cause)
  );

  always #5 clk = ~clk;

  // Word layout: {hold_pc, hold_if, br, except, flush_id, flush_ex,
  //               pc_branch[31:0], epc[31:0], cause[4:0]}
  typedef struct {
    string       nm;
    logic [74:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic setin(input logic r, input logic lu, input logic md,
                       input logic b, input logic [31:0] bt,
                       input logic x, input logic [31:0] xp,
                       input logic [4:0] xc);
    rst       = r;
    load_use  = lu;
    md_start  = md;
    br_req    = b;
    br_target = bt;
    exc_req   = x;
    exc_pc    = xp;
    exc_code  = xc;
  endtask

  task automatic expect_out(input string nm, input logic h, input logic b,
                            input logic x, input logic fi, input logic fe,
                            input logic [31:0] pcb, input logic [31:0] ep,
                            input logic [4:0] ca);
    exp_t e;
    e.nm = nm;
    e.v  = {h, h, b, x, fi, fe, pcb, ep, ca};
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output word.
  initial begin
    exp_t        e;
    logic [74:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hold_pc, hold_if, br, except, flush_id, flush_ex,
               pc_branch, epc, cause};
        n_cmp++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
        end
      end
    end
  end

  initial begin
    setin(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    // Reset applied; BOOT holds fetch.
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Boot: exactly two held cycles; a branch in BOOT is ignored.
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("boot1", 1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    setin(0, 0, 0, 1, 32'h99, 0, 0, 0);
    expect_out("boot2_br_ignored", 1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("run_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Branch wins over load-use.
    setin(0, 1, 0, 1, 32'h40, 0, 0, 0);
    expect_out("br_over_lu", 0, 1, 0, 1, 0, 32'h40, 0, 0);
    tick;

    // Exception wins over branch; the shadow ignores br/md/lu.
    setin(0, 0, 0, 1, 32'h80, 1, 32'h10, 5'd12);
    expect_out("exc_over_br", 0, 0, 1, 1, 1, 0, 0, 0);
    tick;
    setin(0, 1, 1, 1, 32'h80, 0, 0, 0);
    expect_out("exc_shadow", 0, 0, 0, 0, 0, 0, 32'h10, 5'd12);
    tick;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("run_after_shadow", 0, 0, 0, 0, 0, 0, 32'h10, 5'd12);
    tick;

    // Back-to-back exceptions: the second one lands in EXC_SHADOW.
    setin(0, 0, 0, 0, 0, 1, 32'h20, 5'd3);
    expect_out("exc_a", 0, 0, 1, 1, 1, 0, 32'h10, 5'd12);
    tick;
    setin(0, 0, 0, 0, 0, 1, 32'h24, 5'd4);
    expect_out("exc_in_shadow", 0, 0, 1, 1, 1, 0, 32'h20, 5'd3);
    tick;
    setin(0, 0, 0, 1, 32'h77, 0, 0, 0);
    expect_out("shadow_again", 0, 0, 0, 0, 0, 0, 32'h24, 5'd4);
    tick;

    // Mult/div: 32 held cycles, branches inside ignored.
    setin(0, 0, 1, 0, 0, 0, 0, 0);
    expect_out("md_c1", 1, 0, 0, 0, 0, 0, 32'h24, 5'd4);
    tick;
    for (int i = 2; i <= 32; i++) begin
      setin(0, 1, 0, (i >= 10 && i <= 12), 32'h123, 0, 0, 0);
      expect_out($sformatf("md_c%0d", i), 1, 0, 0, 0, 0, 0, 32'h24, 5'd4);
      tick;
    end
    setin(0, 0, 0, 1, 32'h200, 0, 0, 0);
    expect_out("md_done_br", 0, 1, 0, 1, 0, 32'h200, 32'h24, 5'd4);
    tick;

    // Exception in cycle 5 of MD_WAIT aborts the stall.
    setin(0, 0, 1, 0, 0, 0, 0, 0);
    expect_out("md2_c1", 1, 0, 0, 0, 0, 0, 32'h24, 5'd4);
    tick;
    for (int i = 1; i <= 4; i++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("md2_wait%0d", i), 1, 0, 0, 0, 0, 0, 32'h24, 5'd4);
      tick;
    end
    setin(0, 0, 0, 0, 0, 1, 32'h30, 5'd5);
    expect_out("md2_exc", 0, 0, 1, 1, 1, 0, 32'h24, 5'd4);
    tick;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("md2_shadow", 0, 0, 0, 0, 0, 0, 32'h30, 5'd5);
    tick;

    // Load-use held three cycles, then released.
    for (int i = 1; i <= 3; i++) begin
      setin(0, 1, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("lu%0d", i), 1, 0, 0, 0, 1, 0, 32'h30, 5'd5);
      tick;
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("lu_release", 0, 0, 0, 0, 0, 0, 32'h30, 5'd5);
    tick;

    // Reset pulse mid-run: requests ignored, BOOT repeats, EPC cleared.
    setin(1, 0, 0, 0, 0, 1, 32'h55, 5'd9);
    expect_out("rst_in_run", 0, 0, 0, 0, 0, 0, 32'h30, 5'd5);
    tick;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reboot1", 1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    expect_out("reboot2", 1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    expect_out("reboot_run", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
